// File: rtl/oled_text_pkg.sv
// Shared types and constants for the OLED character-buffer controller.
// Geometry is 4 lines x 16 chars; position 0 is the top-left byte of the 512-bit buffer.
package oled_text_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL,
    ST_CLEAR
  } state_t;

  localparam int         LINE_CHARS      = 16;
  localparam int         LINES           = 4;
  localparam logic [5:0] LAST_POS        = 6'd63;
  localparam logic [5:0] LAST_LINE_START = 6'd48;
  localparam logic [7:0] NEWLINE         = 8'h0A;

  // Position p lives in bits [511-8p -: 8].
  function automatic logic [8:0] pos_msb(input logic [5:0] pos);
    return 9'd511 - {pos, 3'b000};
  endfunction

endpackage

// File: rtl/oled_text_ctrl_if.sv
// Requester-facing bundle of oled_text_ctrl: two write ports, clear command and display outputs.
// master = requester side, slave = controller side.
interface oled_text_ctrl_if;
  logic         a_valid;
  logic         a_ready;
  logic [5:0]   a_pos;
  logic [7:0]   a_char;
  logic         b_valid;
  logic         b_ready;
  logic [7:0]   b_char;
  logic         clear_req;
  logic [511:0] display_data;
  logic         update;
  logic [5:0]   cursor_pos;
  logic         busy;

  modport master (
    output a_valid, a_pos, a_char, b_valid, b_char, clear_req,
    input  a_ready, b_ready, display_data, update, cursor_pos, busy
  );

  modport slave (
    input  a_valid, a_pos, a_char, b_valid, b_char, clear_req,
    output a_ready, b_ready, display_data, update, cursor_pos, busy
  );
endinterface

// File: rtl/oled_update_sched.sv
// Rate-limits OLED refresh: one update pulse whenever the buffer is dirty and the gap timer has drained.
// Pulses are registered and spaced at least UPDATE_GAP cycles apart.
module oled_update_sched #(
  parameter int UPDATE_GAP = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_modify,
  output logic o_update
);
  localparam int TW = $clog2(UPDATE_GAP);

  logic [TW-1:0] r_timer;
  logic          r_dirty;
  logic          r_update;
  logic          w_fire;

  assign w_fire   = r_dirty & (r_timer == '0);
  assign o_update = r_update;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer  <= '0;
      r_dirty  <= 1'b1;
      r_update <= 1'b0;
    end else begin
      r_update <= w_fire;
      if (w_fire) begin
        r_timer <= TW'(UPDATE_GAP - 1);
        // A change landing on the pulse cycle must still be shown later.
        r_dirty <= i_modify;
      end else begin
        r_dirty <= r_dirty | i_modify;
        if (r_timer != '0) r_timer <= r_timer - 1'b1;
      end
    end
  end
endmodule

// File: rtl/oled_text_ctrl.sv
// Owns the 64-char display buffer; arbitrates a random-access port (A) and a terminal stream port (B).
// Handshake -> buffer change in 1 cycle; readys only high in IDLE, so transfers are >= 2 cycles apart.
module oled_text_ctrl
  import oled_text_pkg::*;
#(
  parameter int         UPDATE_GAP = 1000,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  oled_text_ctrl_if.slave  bus
);
  localparam logic [511:0] BLANK_ALL = {64{BLANK_CHAR}};

  state_t       r_state;
  state_t       w_next;
  logic [511:0] r_disp;
  logic [5:0]   r_cursor;
  logic [5:0]   r_lat_pos;
  logic [7:0]   r_lat_char;
  logic         r_lat_a;
  logic         r_last_a;
  logic         w_grant_a;
  logic         w_grant_b;
  logic         w_a_rdy;
  logic         w_b_rdy;
  logic         w_modify;
  logic         w_is_nl;
  logic         w_wrap;
  logic         w_update;

  // last_grant loses ties, giving round-robin between the ports.
  assign w_grant_a = bus.a_valid & (~bus.b_valid | ~r_last_a);
  assign w_grant_b = bus.b_valid & ~w_grant_a;
  assign w_is_nl   = (r_lat_char == NEWLINE);
  assign w_wrap    = ~r_lat_a & (w_is_nl ? (r_cursor[5:4] == 2'(LINES - 1))
                                         : (r_cursor == LAST_POS));

  always_comb begin
    w_next   = r_state;
    w_a_rdy  = 1'b0;
    w_b_rdy  = 1'b0;
    w_modify = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.clear_req) begin
          w_next = ST_CLEAR;
        end else begin
          w_a_rdy = w_grant_a;
          w_b_rdy = w_grant_b;
          if (w_grant_a | w_grant_b) w_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_modify = r_lat_a | ~w_is_nl;
        w_next   = w_wrap ? ST_SCROLL : ST_IDLE;
      end
      ST_SCROLL: begin
        w_modify = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_CLEAR: begin
        w_modify = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_disp     <= BLANK_ALL;
      r_cursor   <= '0;
      r_lat_pos  <= '0;
      r_lat_char <= '0;
      r_lat_a    <= 1'b0;
      r_last_a   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_a_rdy) begin
            r_lat_a    <= 1'b1;
            r_lat_pos  <= bus.a_pos;
            r_lat_char <= bus.a_char;
            r_last_a   <= 1'b1;
          end else if (w_b_rdy) begin
            r_lat_a    <= 1'b0;
            r_lat_pos  <= r_cursor;
            r_lat_char <= bus.b_char;
            r_last_a   <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (r_lat_a | ~w_is_nl) r_disp[pos_msb(r_lat_pos) -: 8] <= r_lat_char;
          if (!r_lat_a) begin
            if (w_wrap)       r_cursor <= LAST_LINE_START;
            else if (w_is_nl) r_cursor <= {r_cursor[5:4] + 2'd1, 4'd0};
            else              r_cursor <= r_cursor + 6'd1;
          end
        end
        ST_SCROLL: r_disp <= {r_disp[511-LINE_CHARS*8:0], {LINE_CHARS{BLANK_CHAR}}};
        ST_CLEAR: begin
          r_disp   <= BLANK_ALL;
          r_cursor <= '0;
        end
        default: ;
      endcase
    end
  end

  oled_update_sched #(
    .UPDATE_GAP (UPDATE_GAP)
  ) u_sched (
    .clk      (clk),
    .rst      (rst),
    .i_modify (w_modify),
    .o_update (w_update)
  );

  assign bus.a_ready      = w_a_rdy;
  assign bus.b_ready      = w_b_rdy;
  assign bus.display_data = r_disp;
  assign bus.cursor_pos   = r_cursor;
  assign bus.update       = w_update;
  assign bus.busy         = (r_state != ST_IDLE);
endmodule

// File: doc/oled_text_ctrl.md
Name: oled_text_ctrl

Overview:
- Character-buffer controller in front of the Pmod OLED interface.
- Owns the 64-character display_data buffer and shares it between two requesters: a random-access writer (port A) and a terminal-style stream writer (port B) with auto-advancing cursor, newline and scroll.
- Arbitrates the two ports round-robin, services a clear command, and schedules rate-limited update pulses toward the OLED module.

Parameters:
- UPDATE_GAP, 1000, minimum clk cycles between consecutive update pulses (>=2).
- BLANK_CHAR, 8'h20, fill character for clear, scroll and reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a_valid  in  1  port A write request
- a_ready  out  1  port A accept; transfer when a_valid & a_ready
- a_pos  in  6  port A target position, 0 = top-left, 63 = bottom-right
- a_char  in  8  port A character code
- b_valid  in  1  port B stream request
- b_ready  out  1  port B accept
- b_char  in  8  port B character; 8'h0A = newline
- clear_req  in  1  single-cycle pulse: blank the buffer and home the cursor
- display_data  out  512  buffer; position p occupies bits [511-8p -: 8]
- update  out  1  one-cycle pulse to the OLED module
- cursor_pos  out  6  port B cursor position
- busy  out  1  high when state != IDLE

Behaviour:
- Reset values (synchronous, rst high at clk edge):
  - display_data = 64 x BLANK_CHAR; cursor_pos = 0; update = 0.
  - state = IDLE; last_grant = B (so A wins the first tie).
  - timer = 0; dirty = 1 (first update pulse issues on the first cycle after reset).
- States: IDLE, WRITE, SCROLL, CLEAR.
- IDLE transitions:
  - clear_req has priority: -> CLEAR; both readys stay low that cycle.
  - Else grant one port. If only one port is valid, grant it. If both are valid, grant the port not equal to last_grant.
  - Only the granted port's ready is high; ready is combinational from state, valids and last_grant.
  - On a handshake, latch pos/char and port id, update last_grant, -> WRITE.
- Readys are low in every state except IDLE.
- WRITE (1 cycle):
  - Port A: write char at latched pos; -> IDLE.
  - Port B, char != 0x0A: write at cursor_pos. If cursor_pos == 63: cursor <- 48, -> SCROLL. Else cursor+1, -> IDLE.
  - Port B, char == 0x0A, no write: if cursor line (cursor[5:4]) < 3, cursor <- (line+1)*16, -> IDLE. Else cursor <- 48, -> SCROLL.
- SCROLL (1 cycle): display_data <= {display_data[383:0], 16 x BLANK_CHAR}; -> IDLE.
- CLEAR (1 cycle): all bytes = BLANK_CHAR, cursor_pos = 0; -> IDLE.
- clear_req pulses are honoured only in IDLE; a pulse in any other state is dropped (documented limitation). Port A writes never move the cursor.
- Latency: handshake to buffer change = 1 cycle (in WRITE). Scroll completes 2 cycles after handshake. Minimum 2 cycles between accepted transfers.
- Update scheduler:
  - dirty is set by any buffer modification (WRITE with a char, SCROLL, CLEAR).
  - When dirty & timer == 0: update = 1 for one cycle, timer <- UPDATE_GAP-1, dirty cleared.
  - A modification in the same cycle as the pulse leaves dirty set.
  - timer decrements to 0 and saturates there.
  - A newline that causes no write or scroll does not set dirty.
- A reset asserted mid-operation aborts any state immediately and applies the reset values; a pending latched write is discarded.

Decomposition:
- Package oled_text_pkg holds:
  - state encoding (IDLE/WRITE/SCROLL/CLEAR);
  - constants LINE_CHARS = 16, LINES = 4, LAST_POS = 63, LAST_LINE_START = 48, NEWLINE = 8'h0A;
  - a function mapping position to bit offset.
- One sub-module: oled_update_sched, which holds the timer and dirty flag. Inputs: modify strobe. Output: update pulse.

Test Plan:
- Reset release -> update pulses on the first cycle after reset; display_data all 8'h20, cursor_pos 0; next pulse no earlier than UPDATE_GAP cycles later, and only if dirty.
- Port A writes 8'h41 at pos 5 -> byte [471:464] = 8'h41 one cycle after handshake; cursor_pos stays 0; one update after the gap expires.
- a_valid and b_valid held high together, 4 transfers -> grants alternate A, B, A, B, each 2 cycles apart.
- Port B streams 64 chars 8'h30..8'h6F -> after the 64th char, SCROLL occurs; line 0 holds 8'h40..8'h4F, line 3 is all 8'h20, cursor_pos = 48.
- Port B sends 8'h0A at cursor 20 -> cursor 32, no dirty. At cursor 50 -> scroll, cursor 48.
- Check clear and reset priority:
  - clear_req in the same cycle as a_valid in IDLE -> a_ready low, buffer all 8'h20, cursor 0.
  - rst asserted during SCROLL -> reset values next cycle.
